// File: rtl/ps2_mouse_ctrl_if.sv
// rtl/ps2_mouse_ctrl_if.sv - link-layer bundle between the mouse controller and the PS/2 transmitter/receiver
//
// Signals:
//   wr_ps2       one-cycle command-send strobe to the transmitter
//   din[7:0]     command byte, valid while wr_ps2=1
//   tx_idle      transmitter idle
//   tx_done_tick transmitter finished the frame
//   rx_en        receiver enable
//   rx_done_tick receiver byte valid
//   dout[7:0]    received byte, qualified by rx_done_tick
// Modports:
//   master  the mouse controller
//   slave   the PS/2 link layer
interface ps2_mouse_ctrl_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;

  modport master (
    output wr_ps2, din, rx_en,
    input  tx_idle, tx_done_tick, rx_done_tick, dout
  );

  modport slave (
    input  wr_ps2, din, rx_en,
    output tx_idle, tx_done_tick, rx_done_tick, dout
  );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse protocol controller (init handshake + 3-byte packet assembly)
//
// Initialises the mouse through the PS/2 transmitter, waits for the 0xFA
// acknowledge with timeout/retry, then assembles stream-mode packets into
// signed X/Y deltas, buttons and overflow flags.
//
// Optional feature macro: PS2_MOUSE_RESET_CMD_EN
//   defined   : 0xFF reset, expect 0xFA, 0xAA, 0x00, then 0xF4 / 0xFA
//   undefined : 0xF4 / 0xFA only
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   link         link-layer bundle (ps2_mouse_ctrl_if.master)
//   xm[8:0]      signed X delta {sign, byte2}
//   ym[8:0]      signed Y delta {sign, byte3}
//   btnm[2:0]    {middle, right, left}
//   ovf[1:0]     {Y overflow, X overflow}
//   m_done_tick  one-cycle pulse when a new packet is presented
//   init_done    initialisation complete, streaming
//   init_err     retries exhausted, held until reset
module ps2_mouse_ctrl #(
  parameter logic [19:0] ACK_TIMEOUT = 20'hFFFFF,
  parameter int          MAX_RETRY   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_mouse_ctrl_if.master        link,
  output logic [8:0]              xm,
  output logic [8:0]              ym,
  output logic [2:0]              btnm,
  output logic [1:0]              ovf,
  output logic                    m_done_tick,
  output logic                    init_done,
  output logic                    init_err
);

  localparam logic [2:0] ST_CMD      = 3'd0;
  localparam logic [2:0] ST_WAIT_TX  = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_PACK1    = 3'd3;
  localparam logic [2:0] ST_PACK2    = 3'd4;
  localparam logic [2:0] ST_PACK3    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
`ifdef PS2_MOUSE_RESET_CMD_EN
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID  = 8'h00;
  localparam logic [7:0] FIRST_CMD   = CMD_RESET;
`else
  localparam logic [7:0] FIRST_CMD   = CMD_ENABLE;
`endif

  logic [2:0]  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  retry_q, retry_d;
  logic [19:0] tmo_q, tmo_d;
  // byte1 without its always-one sync bit: {ovf[1:0], ysign, xsign, btn[2:0]}
  logic [6:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic [8:0]  xm_q, xm_d;
  logic [8:0]  ym_q, ym_d;
  logic [2:0]  btnm_q, btnm_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        init_done_q, init_done_d;
  logic        fail;
`ifdef PS2_MOUSE_RESET_CMD_EN
  // 0: ack of 0xFF, 1: self-test 0xAA, 2: device ID 0x00, 3: ack of 0xF4
  logic [1:0]  step_q, step_d;
  logic        restart;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    xm_d        = xm_q;
    ym_d        = ym_q;
    btnm_d      = btnm_q;
    ovf_d       = ovf_q;
    init_done_d = init_done_q;
    fail        = 1'b0;
`ifdef PS2_MOUSE_RESET_CMD_EN
    step_d      = step_q;
    restart     = 1'b0;
`endif

    case (state_q)
      ST_CMD: begin
        if (link.tx_idle) state_d = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (link.tx_done_tick) begin
          tmo_d   = '0;
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        tmo_d = tmo_q + 20'd1;
        // a received byte wins over a simultaneous timeout
        if (link.rx_done_tick) begin
`ifdef PS2_MOUSE_RESET_CMD_EN
          case (step_q)
            2'd0: begin
              if (link.dout == RSP_ACK) begin
                step_d  = 2'd1;
                tmo_d   = '0;
                retry_d = '0;
              end else begin
                fail    = 1'b1;
                restart = 1'b1;
              end
            end
            2'd1: begin
              if (link.dout == RSP_BAT_OK) begin
                step_d = 2'd2;
                tmo_d  = '0;
              end else begin
                fail    = 1'b1;
                restart = 1'b1;
              end
            end
            2'd2: begin
              if (link.dout == RSP_DEV_ID) begin
                step_d  = 2'd3;
                cmd_d   = CMD_ENABLE;
                state_d = ST_CMD;
              end else begin
                fail    = 1'b1;
                restart = 1'b1;
              end
            end
            default: begin
              if (link.dout == RSP_ACK) begin
                retry_d     = '0;
                init_done_d = 1'b1;
                state_d     = ST_PACK1;
              end else begin
                fail    = 1'b1;
                restart = 1'b1;
              end
            end
          endcase
`else
          if (link.dout == RSP_ACK) begin
            retry_d     = '0;
            init_done_d = 1'b1;
            state_d     = ST_PACK1;
          end else begin
            fail = 1'b1;
          end
`endif
        end else if (tmo_q == ACK_TIMEOUT) begin
          fail = 1'b1;
        end

        if (fail) begin
          retry_d = retry_q + 8'd1;
          if (int'(retry_q) + 1 < MAX_RETRY) state_d = ST_CMD;
          else                               state_d = ST_ERR;
`ifdef PS2_MOUSE_RESET_CMD_EN
          // a timeout re-sends the command in flight: 0xFF covers steps 0-2
          if (restart || step_q != 2'd3) begin
            step_d = 2'd0;
            cmd_d  = CMD_RESET;
          end
`endif
        end
      end

      ST_PACK1: begin
        // bit3 of byte1 is always 1; anything else is a misaligned byte
        if (link.rx_done_tick && link.dout[3]) begin
          b1_d    = {link.dout[7:4], link.dout[2:0]};
          state_d = ST_PACK2;
        end
      end

      ST_PACK2: begin
        if (link.rx_done_tick) begin
          b2_d    = link.dout;
          state_d = ST_PACK3;
        end
      end

      ST_PACK3: begin
        // outputs load here so they are already valid during the DONE tick
        if (link.rx_done_tick) begin
          xm_d    = {b1_q[3], b2_q};
          ym_d    = {b1_q[4], link.dout};
          btnm_d  = b1_q[2:0];
          ovf_d   = b1_q[6:5];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_PACK1;
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CMD;
      cmd_q       <= FIRST_CMD;
      retry_q     <= '0;
      tmo_q       <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      btnm_q      <= '0;
      ovf_q       <= '0;
      init_done_q <= 1'b0;
`ifdef PS2_MOUSE_RESET_CMD_EN
      step_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      xm_q        <= xm_d;
      ym_q        <= ym_d;
      btnm_q      <= btnm_d;
      ovf_q       <= ovf_d;
      init_done_q <= init_done_d;
`ifdef PS2_MOUSE_RESET_CMD_EN
      step_q      <= step_d;
`endif
    end
  end

  // the strobe follows tx_idle in the first CMD cycle; masked while reset is held
  assign link.wr_ps2 = (state_q == ST_CMD) && link.tx_idle && !reset;
  assign link.din    = cmd_q;
  assign link.rx_en  = (state_q == ST_WAIT_ACK) || (state_q == ST_PACK1) ||
                       (state_q == ST_PACK2)    || (state_q == ST_PACK3) ||
                       (state_q == ST_DONE);

  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnm        = btnm_q;
  assign ovf         = ovf_q;
  assign m_done_tick = (state_q == ST_DONE);
  assign init_done   = init_done_q;
  assign init_err    = (state_q == ST_ERR);

endmodule
